// File: rtl/ppt_input_conditioner.sv
// N-channel input conditioner: synchronise, tick-based debounce, mode-qualified
// edge detection and per-channel edge counting with sticky overflow.
module ppt_input_conditioner #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 3,
  parameter int CNT_W       = 8,
  parameter int SATURATE    = 1,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_CH-1:0]  in_async,
  input  logic [1:0]       edge_mode,
  input  logic             clr,
  input  logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  level,
  output logic [N_CH-1:0]  edge_pulse,
  output logic [CNT_W-1:0] count_out,
  output logic [N_CH-1:0]  ovf
);

  localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  sync_d [SYNC_STAGES];
  logic [DEB_W-1:0] deb_q  [N_CH];
  logic [DEB_W-1:0] deb_d  [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [N_CH-1:0]  level_q, level_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  edge_pulse_q, edge_pulse_d;
  logic [N_CH-1:0]  ovf_q, ovf_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic [N_CH-1:0]  s;
  logic [N_CH-1:0]  chg;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = in_async;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
  end

  // Debounce: a new level must be seen on DEB_CNT consecutive ticks.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_CH; i++) begin
      deb_d[i] = deb_q[i];
      if (tick) begin
        if (DEB_CNT == 0) begin
          level_d[i] = s[i];
          deb_d[i]   = '0;
        end else if (s[i] == level_q[i]) begin
          deb_d[i] = '0;
        end else if (deb_q[i] == DEB_W'(DEB_CNT - 1)) begin
          level_d[i] = s[i];
          deb_d[i]   = '0;
        end else begin
          deb_d[i] = deb_q[i] + 1'b1;
        end
      end
    end
  end

  // Mode is captured on the clock where level changes; the pulse follows a clock later.
  always_comb begin
    chg = level_d ^ level_q;
    case (edge_mode)
      2'b01:   pend_d = chg & level_d;
      2'b10:   pend_d = chg & ~level_d;
      2'b11:   pend_d = chg;
      default: pend_d = '0;
    endcase
    edge_pulse_d = pend_q;
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (edge_pulse_q[i]) begin
        if (cnt_q[i] == {CNT_W{1'b1}}) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Out-of-range sel matches no channel and reads back 0.
  always_comb begin
    count_out_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) count_out_d = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < N_CH; i++) begin
        deb_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      level_q      <= '0;
      pend_q       <= '0;
      edge_pulse_q <= '0;
      ovf_q        <= '0;
      count_out_q  <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < N_CH; i++) begin
        deb_q[i] <= deb_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      level_q      <= level_d;
      pend_q       <= pend_d;
      edge_pulse_q <= edge_pulse_d;
      ovf_q        <= ovf_d;
      count_out_q  <= count_out_d;
    end
  end

  assign level      = level_q;
  assign edge_pulse = edge_pulse_q;
  assign count_out  = count_out_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_ppt_input_conditioner.sv
// Bench for ppt_input_conditioner: default instance plus two 4-bit counter
// instances (saturating and wrapping) checked against a behavioural model.
module tb_ppt_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic [7:0] in_async = '0;
  logic [1:0] edge_mode = 2'b01;
  logic       clr = 1'b0;
  logic [2:0] sel = '0;

  logic [7:0] level_a, edge_a, ovf_a, cout_a;
  logic [7:0] level_b, edge_b, ovf_b;
  logic [7:0] level_c, edge_c, ovf_c;
  logic [3:0] cout_b, cout_c;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ppt_input_conditioner u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_async(in_async), .edge_mode(edge_mode),
    .clr(clr), .sel(sel), .level(level_a), .edge_pulse(edge_a), .count_out(cout_a), .ovf(ovf_a));

  ppt_input_conditioner #(.CNT_W(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_async(in_async), .edge_mode(edge_mode),
    .clr(clr), .sel(sel), .level(level_b), .edge_pulse(edge_b), .count_out(cout_b), .ovf(ovf_b));

  ppt_input_conditioner #(.CNT_W(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_async(in_async), .edge_mode(edge_mode),
    .clr(clr), .sel(sel), .level(level_c), .edge_pulse(edge_c), .count_out(cout_c), .ovf(ovf_c));

  // Behavioural model: index 0 = default, 1 = 4-bit saturating, 2 = 4-bit wrapping
  logic [7:0] sq[$];
  logic [7:0] m_level = '0, m_pend = '0, m_edge = '0;
  logic [31:0] th [8];
  int nth [8];
  int mcnt [3][8];
  logic [7:0] movf [3];
  int mcout [3];
  int mmax [3] = '{255, 15, 15};
  bit msat [3] = '{1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    sq.push_back(8'h00);
    sq.push_back(8'h00);
    m_level = '0; m_pend = '0; m_edge = '0;
    for (int i = 0; i < 8; i++) begin
      th[i] = '0; nth[i] = 0;
    end
    for (int d = 0; d < 3; d++) begin
      movf[d] = '0; mcout[d] = 0;
      for (int i = 0; i < 8; i++) mcnt[d][i] = 0;
    end
  endtask

  // One clock of the model, all reads from state held before this edge.
  task automatic model_step();
    logic [7:0] s, nl, chg;
    for (int d = 0; d < 3; d++) mcout[d] = mcnt[d][sel];
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        if (clr) begin
          mcnt[d][i] = 0;
          movf[d][i] = 1'b0;
        end else if (m_edge[i]) begin
          if (mcnt[d][i] == mmax[d]) begin
            movf[d][i] = 1'b1;
            if (!msat[d]) mcnt[d][i] = 0;
          end else begin
            mcnt[d][i] = mcnt[d][i] + 1;
          end
        end
      end
    end
    m_edge = m_pend;
    s = sq.pop_front();
    sq.push_back(in_async);
    nl = m_level;
    if (tick) begin
      for (int i = 0; i < 8; i++) begin
        th[i] = {th[i][30:0], s[i]};
        nth[i]++;
        // accept once the last three tick samples all disagree with the level
        if (nth[i] >= 3 && th[i][2:0] == (m_level[i] ? 3'b000 : 3'b111)) begin
          nl[i] = s[i];
          nth[i] = 0;
        end
      end
    end
    chg = nl ^ m_level;
    case (edge_mode)
      2'b01:   m_pend = chg & nl;
      2'b10:   m_pend = chg & ~nl;
      2'b11:   m_pend = chg;
      default: m_pend = '0;
    endcase
    m_level = nl;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("level", {24'd0, level_a}, {24'd0, m_level});
        check("edge", {24'd0, edge_a}, {24'd0, m_edge});
        check("level_b", {24'd0, level_b}, {24'd0, m_level});
        check("level_c", {24'd0, level_c}, {24'd0, m_level});
        check("ovf_a", {24'd0, ovf_a}, {24'd0, movf[0]});
        check("ovf_b", {24'd0, ovf_b}, {24'd0, movf[1]});
        check("ovf_c", {24'd0, ovf_c}, {24'd0, movf[2]});
        check("cout_a", {24'd0, cout_a}, mcout[0]);
        check("cout_b", {28'd0, cout_b}, mcout[1]);
        check("cout_c", {28'd0, cout_c}, mcout[2]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle(input int ch, input int times, input int hold);
    for (int t = 0; t < times; t++) begin
      in_async[ch] = ~in_async[ch];
      step(hold);
    end
  endtask

  initial begin
    step(1);
    cmp_en = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(1);
    check("rst_level", {24'd0, level_a}, 32'd0);
    check("rst_count", {24'd0, cout_a}, 32'd0);

    // ch0 step: level after 5 clk, pulse one clk later, count 1
    in_async[0] = 1'b1;
    step(4);
    check("t1_level_early", {31'd0, level_a[0]}, 32'd0);
    step(1);
    check("t1_level", {31'd0, level_a[0]}, 32'd1);
    check("t1_edge_early", {31'd0, edge_a[0]}, 32'd0);
    step(1);
    check("t1_edge", {31'd0, edge_a[0]}, 32'd1);
    step(1);
    check("t1_edge_end", {31'd0, edge_a[0]}, 32'd0);
    step(2);
    check("t1_count", {24'd0, cout_a}, 32'd1);

    // 2-clk glitch on ch3 is rejected
    in_async[3] = 1'b1;
    step(2);
    in_async[3] = 1'b0;
    step(12);
    sel = 3'd3;
    step(2);
    check("t2_level", {31'd0, level_a[3]}, 32'd0);
    check("t2_count", {24'd0, cout_a}, 32'd0);

    // both-edge then falling-only mode on ch1
    edge_mode = 2'b11;
    sel = 3'd1;
    toggle(1, 4, 10);
    step(2);
    check("t3_both", {24'd0, cout_a}, 32'd4);
    edge_mode = 2'b10;
    toggle(1, 4, 10);
    step(2);
    check("t3_fall", {24'd0, cout_a}, 32'd6);

    // clr coinciding with edge_pulse[2]
    edge_mode = 2'b01;
    sel = 3'd2;
    in_async[2] = 1'b1;
    step(6);
    check("t5_edge", {31'd0, edge_a[2]}, 32'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(2);
    check("t5_count_clr", {24'd0, cout_a}, 32'd0);
    check("t5_ovf_clr", {31'd0, ovf_a[2]}, 32'd0);
    toggle(2, 2, 10);
    step(2);
    check("t5_count_next", {24'd0, cout_a}, 32'd1);

    // 17 rising edges on ch4: 4-bit saturating vs wrapping
    sel = 3'd4;
    toggle(4, 34, 8);
    step(4);
    check("t4_sat_count", {28'd0, cout_b}, 32'd15);
    check("t4_sat_ovf", {31'd0, ovf_b[4]}, 32'd1);
    check("t4_wrap_count", {28'd0, cout_c}, 32'd1);
    check("t4_wrap_ovf", {31'd0, ovf_c[4]}, 32'd1);
    check("t4_wide_count", {24'd0, cout_a}, 32'd17);

    // reset mid-debounce with tick gated off
    in_async[5] = 1'b1;
    step(4);
    tick = 1'b0;
    step(2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_level", {24'd0, level_a}, 32'd0);
    check("t6_edge", {24'd0, edge_a}, 32'd0);
    check("t6_cout", {24'd0, cout_a}, 32'd0);
    check("t6_ovf_b", {24'd0, ovf_b}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(10);
    check("t6_hold", {24'd0, level_a}, 32'd0);
    tick = 1'b1;
    step(5);
    check("t6_resume", {24'd0, level_a}, 32'h25);

    // slow tick: one in three clocks
    sel = 3'd6;
    in_async[6] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick = (k % 3 == 0);
      step(1);
    end
    tick = 1'b1;
    step(4);
    check("t7_level", {31'd0, level_a[6]}, 32'd1);
    check("t7_count", {24'd0, cout_a}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
